// File: rtl/ula_pkg.sv
// Shared types and defaults for the ULA op scheduler.
// Holds the state enum, width constants and the multi-cycle opcode test.
package ula_pkg;

   localparam int OP_W              = 4;
   localparam int DATA_W_DEF        = 8;
   localparam int RES_W_DEF         = 16;
   localparam int MULTI_OP_BASE_DEF = 12;
   localparam int MULTI_LAT_DEF     = 4;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   function automatic logic is_multi(
      input logic [OP_W-1:0] op,
      input int              base
   );
      return int'(op) >= base;
   endfunction

endpackage

// File: rtl/ula_op_scheduler_rr_arbiter_2.sv
// Two-way round-robin grant for the ULA op scheduler.
// A lone valid always wins; a tie goes to the requester at rr_ptr.
module rr_arbiter_2 (
   input  logic [1:0] valid,
   input  logic       rr_ptr,
   input  logic       enable,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/ula_op_scheduler.sv
// Shares one ULA datapath between two requesters (IDLE/EXEC/RESP).
// Define ULA_OP_SCHEDULER_PERF_EN to add grant and stall counters.
module ula_op_scheduler
   import ula_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int RES_W         = RES_W_DEF,
   parameter int MULTI_OP_BASE = MULTI_OP_BASE_DEF,
   parameter int MULTI_LAT     = MULTI_LAT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   selectors,
   input  logic [RES_W-1:0]  alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RES_W-1:0]  rsp_result,
`ifdef ULA_OP_SCHEDULER_PERF_EN
   output logic [15:0]       grant_cnt0,
   output logic [15:0]       grant_cnt1,
   output logic [15:0]       stall_cnt,
`endif
   output logic              rsp_id
);

   localparam logic [3:0] LAT_M1 = 4'(MULTI_LAT - 1);

   state_t            state;
   logic              rr_ptr;
   logic [3:0]        count;
   logic [1:0]        grant;
   logic              accept;
   logic              acc_id;
   logic [OP_W-1:0]   op_sel;
   logic [DATA_W-1:0] a_sel;
   logic [DATA_W-1:0] b_sel;

   // Grants are only offered in IDLE and never while reset is held.
   rr_arbiter_2 u_arb (
      .valid  ({req1_valid, req0_valid}),
      .rr_ptr (rr_ptr),
      .enable (state == IDLE && !reset),
      .grant  (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign accept     = |grant;
   assign acc_id     = grant[1];
   assign op_sel     = acc_id ? req1_op : req0_op;
   assign a_sel      = acc_id ? req1_a  : req0_a;
   assign b_sel      = acc_id ? req1_b  : req0_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= 1'b0;
         count      <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         selectors  <= '0;
         rsp_result <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  selectors <= op_sel;
                  alu_a     <= a_sel;
                  alu_b     <= b_sel;
                  rsp_id    <= acc_id;
                  rr_ptr    <= ~acc_id;
                  count     <= is_multi(op_sel, MULTI_OP_BASE)
                               ? LAT_M1 : 4'd0;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               if (count == 4'd0) begin
                  rsp_result <= alu_result;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else begin
                  count <= count - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ULA_OP_SCHEDULER_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
         stall_cnt  <= '0;
      end else begin
         if (grant[0]) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (grant[1]) grant_cnt1 <= grant_cnt1 + 16'd1;
         if (rsp_valid && !rsp_ready) stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ula_op_scheduler.sv
// Directed bench for ula_op_scheduler.
// Datapath model returns {a ^ cycle, b} so capture timing is visible.
module tb_ula_op_scheduler;

   localparam int LAT_M = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0_valid = 1'b0;
   logic        req0_ready;
   logic [3:0]  req0_op = '0;
   logic [7:0]  req0_a = '0;
   logic [7:0]  req0_b = '0;
   logic        req1_valid = 1'b0;
   logic        req1_ready;
   logic [3:0]  req1_op = '0;
   logic [7:0]  req1_a = '0;
   logic [7:0]  req1_b = '0;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [3:0]  selectors;
   logic [15:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_result;
   logic        rsp_id;
`ifdef ULA_OP_SCHEDULER_PERF_EN
   logic [15:0] grant_cnt0;
   logic [15:0] grant_cnt1;
   logic [15:0] stall_cnt;
`endif

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign alu_result = {alu_a ^ cyc[7:0], alu_b};

   ula_op_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .selectors  (selectors),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
`ifdef ULA_OP_SCHEDULER_PERF_EN
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1),
      .stall_cnt  (stall_cnt),
`endif
      .rsp_id     (rsp_id)
   );

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      reset      = 1'b0;
   endtask

   task automatic do_op(
      input bit         id,
      input logic [3:0] op,
      input logic [7:0] a,
      input logic [7:0] b,
      input int         stall,
      input bit         hold_other,
      input string      nm
   );
      int          n;
      int          lat;
      int          t;
      logic [15:0] exp;
      lat = (op >= 4'd12) ? LAT_M : 1;
      @(negedge clk);
      rsp_ready = 1'b0;
      if (id == 1'b0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end
      #1;
      n = 0;
      while (!(id ? req1_ready : req0_ready) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL %s ready_timeout waited=%0d limit=20", nm, n);
      end
      checks++;
      if ((id ? req0_ready : req1_ready) !== 1'b0) begin
         errors++;
         $display("FAIL %s other_ready got=1 want=0", nm);
      end
      t   = cyc;
      exp = {a ^ 8'(t + lat), b};
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (hold_other) begin
         if (id == 1'b0) begin
            req1_valid = 1'b1; req1_op = 4'd5;
         end else begin
            req0_valid = 1'b1; req0_op = 4'd5;
         end
      end
      #1;
      for (int k = 1; k <= lat; k++) begin
         if (k > 1) begin
            @(negedge clk); #1;
         end
         checks++;
         if ({selectors, alu_a, alu_b} !== {op, a, b}) begin
            errors++;
            $display("FAIL %s dp_hold k=%0d got=%h want=%h", nm, k,
                     {selectors, alu_a, alu_b}, {op, a, b});
         end
         checks++;
         if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
            errors++;
            $display("FAIL %s exec_flags k=%0d got=%b want=000", nm, k,
                     {rsp_valid, req0_ready, req1_ready});
         end
      end
      @(negedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, id, exp}) begin
         errors++;
         $display("FAIL %s rsp got=%b/%b/%h want=1/%b/%h", nm,
                  rsp_valid, rsp_id, rsp_result, id, exp);
      end
      for (int s = 0; s < stall; s++) begin
         @(negedge clk); #1;
         checks++;
         if ({rsp_valid, rsp_id, rsp_result, req0_ready, req1_ready}
             !== {1'b1, id, exp, 2'b00}) begin
            errors++;
            $display("FAIL %s stall s=%0d got=%b/%b/%h/%b%b want=1/%b/%h/00",
                     nm, s, rsp_valid, rsp_id, rsp_result,
                     req0_ready, req1_ready, id, exp);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s rsp_drop got=%b want=0", nm, rsp_valid);
      end
      if (hold_other) begin
         checks++;
         if ((id ? req0_ready : req1_ready) !== 1'b1) begin
            errors++;
            $display("FAIL %s next_accept got=0 want=1", nm);
         end
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset      = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(negedge clk);
      @(negedge clk); #1;
      checks++;
      if ({alu_a, alu_b, selectors, rsp_result, rsp_valid, rsp_id,
           req0_ready, req1_ready} !== '0) begin
         errors++;
         $display("FAIL reset_state got=%h/%h/%h/%h/%b/%b/%b%b want=all 0",
                  alu_a, alu_b, selectors, rsp_result, rsp_valid, rsp_id,
                  req0_ready, req1_ready);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset      = 1'b0;
   endtask

   task automatic test_single();
      do_op(1'b0, 4'd3, 8'h12, 8'h34, 0, 1'b0, "single");
   endtask

   task automatic test_multi();
      do_op(1'b1, 4'd12, 8'hA5, 8'h5A, 0, 1'b0, "multi_12");
      do_op(1'b1, 4'd11, 8'h0F, 8'hF0, 0, 1'b0, "single_11");
      do_op(1'b0, 4'd15, 8'h33, 8'h77, 0, 1'b0, "multi_15");
   endtask

   task automatic test_backpressure();
      do_op(1'b0, 4'd4, 8'hC3, 8'h3C, 5, 1'b1, "backpressure");
   endtask

   task automatic test_back_to_back();
      int ng;
      apply_reset();
      req0_valid = 1'b1; req0_op = 4'd1; req0_a = 8'h01; req0_b = 8'h02;
      req1_valid = 1'b1; req1_op = 4'd2; req1_a = 8'h03; req1_b = 8'h04;
      rsp_ready  = 1'b1;
      ng = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks++;
         if ((i % 3) == 0) begin
            if ({req1_ready, req0_ready} !== ((ng % 2) ? 2'b10 : 2'b01)) begin
               errors++;
               $display("FAIL rr_grant i=%0d got=%b%b want=%0s", i,
                        req1_ready, req0_ready, (ng % 2) ? "10" : "01");
            end
            ng++;
         end else if ({req1_ready, req0_ready} !== 2'b00) begin
            errors++;
            $display("FAIL rr_busy_ready i=%0d got=%b%b want=00", i,
                     req1_ready, req0_ready);
         end
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_exec();
      int n;
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 4'd13; req0_a = 8'h99; req0_b = 8'h66;
      #1;
      n = 0;
      while (!req0_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL midrst ready_timeout waited=%0d limit=20", n);
      end
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({alu_a, alu_b, selectors, rsp_result, rsp_valid, rsp_id}
          !== '0) begin
         errors++;
         $display("FAIL midrst_state got=%h/%h/%h/%h/%b/%b want=all 0",
                  alu_a, alu_b, selectors, rsp_result, rsp_valid, rsp_id);
      end
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
         errors++;
         $display("FAIL midrst_tie got=%b%b want=01", req1_ready, req0_ready);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_rsp i=%0d got=1 want=0", i);
         end
      end
   endtask

`ifdef ULA_OP_SCHEDULER_PERF_EN
   task automatic test_perf();
      apply_reset();
      checks++;
      if ({grant_cnt0, grant_cnt1, stall_cnt} !== '0) begin
         errors++;
         $display("FAIL perf_reset got=%h/%h/%h want=0/0/0",
                  grant_cnt0, grant_cnt1, stall_cnt);
      end
      do_op(1'b0, 4'd1, 8'h10, 8'h20, 0, 1'b0, "perf_a");
      do_op(1'b1, 4'd2, 8'h11, 8'h21, 0, 1'b0, "perf_b");
      do_op(1'b0, 4'd12, 8'h12, 8'h22, 4, 1'b0, "perf_c");
      do_op(1'b1, 4'd3, 8'h13, 8'h23, 0, 1'b0, "perf_d");
      do_op(1'b0, 4'd4, 8'h14, 8'h24, 0, 1'b0, "perf_e");
      checks++;
      if ({grant_cnt0, grant_cnt1, stall_cnt}
          !== {16'd3, 16'd2, 16'd4}) begin
         errors++;
         $display("FAIL perf_counts got=%0d/%0d/%0d want=3/2/4",
                  grant_cnt0, grant_cnt1, stall_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_exec();
`ifdef ULA_OP_SCHEDULER_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
